mem_wb_stage: RTL

//  Memory-access stage plus MEM/WB pipeline register. Feeds the register file's

---
 rtl/mem_wb_stage.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// Memory-access stage with a fixed-latency SRAM access FSM and the MEM/WB
// pipeline register that feeds the register-file write port.
module mem_wb_stage #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic              wb_en_in,
    input  logic [3:0]        dest_in,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] st_val,
    output logic              freeze,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_we_n,
    output logic              sram_oe_n,
    output logic [DATA_W-1:0] Result_WB,
    output logic [3:0]        Dest_wb,
    output logic              writeBackEn
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              is_store_r;
    logic [DATA_W-1:0] rdata_r;
    logic              req_s;
    logic              freeze_s;
    logic [DATA_W-1:0] addr_diff_s;

    // Request decode, byte-to-word address translation and stall generation
    always_comb begin
        req_s       = mem_r_en | mem_w_en;
        addr_diff_s = alu_res - DATA_W'(BASE_ADDR);
        freeze_s    = 1'b0;
        if (rst) begin
            // a reset aborts the access immediately, including the stall
            freeze_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    freeze_s = req_s;
                ACCESS:  freeze_s = 1'b1;
                DONE:    freeze_s = 1'b0;
                default: freeze_s = 1'b0;
            endcase
        end
    end

    assign freeze = freeze_s;

    // SRAM access sequencer: strobes are registered so they are low exactly in ACCESS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            is_store_r <= 1'b0;
            rdata_r    <= {DATA_W{1'b0}};
            sram_addr  <= {ADDR_W{1'b0}};
            sram_wdata <= {DATA_W{1'b0}};
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        sram_addr  <= addr_diff_s[ADDR_W+1:2];
                        sram_wdata <= st_val;
                        is_store_r <= mem_w_en;
                        cnt_r      <= CNT_W'(WAIT_CYCLES - 1);
                        sram_we_n  <= ~mem_w_en;
                        sram_oe_n  <= mem_w_en;
                        state_r    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        if (!is_store_r) begin
                            rdata_r <= sram_rdata;
                        end
                        sram_we_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                DONE: begin
                    sram_we_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    state_r   <= IDLE;
                end
                default: begin
                    sram_we_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    // MEM/WB register: inserts bubbles while stalled, otherwise captures the result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Result_WB   <= {DATA_W{1'b0}};
            Dest_wb     <= 4'd0;
            writeBackEn <= 1'b0;
        end else if (freeze_s) begin
            writeBackEn <= 1'b0;
        end else begin
            writeBackEn <= wb_en_in;
            Dest_wb     <= dest_in;
            Result_WB   <= (mem_r_en & ~mem_w_en) ? rdata_r : alu_res;
        end
    end

endmodule
